// File: rtl/elevator_pkg.sv
// Shared constants, state encoding and floor-mask helpers for the three-floor elevator.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 3;
  localparam int unsigned POS_MAX    = 4;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    DOOR_OPEN,
    MOVING
  } state_e;

  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int unsigned g = 0; g < NUM_FLOORS; g++) m[g] = ({30'd0, f} == g);
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int unsigned g = 0; g < NUM_FLOORS; g++) m[g] = ({30'd0, f} < g);
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int unsigned g = 0; g < NUM_FLOORS; g++) m[g] = ({30'd0, f} > g);
    return m;
  endfunction

endpackage

// File: rtl/elevator_request_reg.sv
// Pending hall/cabin request bits with set/clear logic and the
// here/above/below/ahead flags evaluated against a selected floor.
module elevator_request_reg
  import elevator_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] button_up,
  input  logic [NUM_FLOORS-1:0] button_down,
  input  logic [NUM_FLOORS-1:0] button_in,
  input  logic [1:0]            floor,
  input  logic [1:0]            dir,
  input  logic                  clear,
  input  logic                  suppress,
  output logic [NUM_FLOORS-1:0] req_up,
  output logic [NUM_FLOORS-1:0] req_down,
  output logic [NUM_FLOORS-1:0] req_in,
  output logic                  here,
  output logic                  above,
  output logic                  below,
  output logic                  ahead,
  output logic                  stop_req,
  output logic                  press_here
);

  localparam logic [NUM_FLOORS-1:0] UP_VALID   = 3'b011;
  localparam logic [NUM_FLOORS-1:0] DOWN_VALID = 3'b110;

  logic [NUM_FLOORS-1:0] req_up_q, req_up_d;
  logic [NUM_FLOORS-1:0] req_down_q, req_down_d;
  logic [NUM_FLOORS-1:0] req_in_q, req_in_d;

  logic [NUM_FLOORS-1:0] fl_oh, up_b, dn_b, keep, drop, any_req;

  always_comb begin
    fl_oh = floor_onehot(floor);
    up_b  = button_up & UP_VALID;
    dn_b  = button_down & DOWN_VALID;
    // Door-open presses at this floor only extend the dwell; clear beats set.
    keep  = suppress ? ~fl_oh : '1;
    drop  = clear ? ~fl_oh : '1;

    req_up_d   = (req_up_q | (up_b & keep)) & drop;
    req_down_d = (req_down_q | (dn_b & keep)) & drop;
    req_in_d   = (req_in_q | (button_in & keep)) & drop;

    press_here = |((up_b | dn_b | button_in) & fl_oh);

    any_req  = req_up_q | req_down_q | req_in_q;
    here     = |(any_req & fl_oh);
    above    = |(any_req & above_mask(floor));
    below    = |(any_req & below_mask(floor));
    ahead    = ((dir == DIR_UP) && above) || ((dir == DIR_DOWN) && below);
    stop_req = (|(req_in_q & fl_oh))
            || ((dir == DIR_UP) && (|(req_up_q & fl_oh)))
            || ((dir == DIR_DOWN) && (|(req_down_q & fl_oh)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_up_q   <= '0;
      req_down_q <= '0;
      req_in_q   <= '0;
    end else begin
      req_up_q   <= req_up_d;
      req_down_q <= req_down_d;
      req_in_q   <= req_in_d;
    end
  end

  assign req_up   = req_up_q;
  assign req_down = req_down_q;
  assign req_in   = req_in_q;

endmodule

// File: rtl/elevator_sequencer.sv
// Three-floor elevator sequencer: request latching, half-floor position
// tracking and the IDLE / DOOR_OPEN / MOVING dwell-and-travel FSM.
module elevator_sequencer
  import elevator_pkg::*;
#(
  parameter int unsigned DOOR_CYCLES   = 4,
  parameter int unsigned TRAVEL_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] button_up,
  input  logic [2:0] button_down,
  input  logic [2:0] button_in,
  output logic [1:0] floor_cur,
  output logic       half_cur,
  output logic       open_cur,
  output logic [1:0] dir_cur,
  output logic [8:0] pending,
  output logic       busy
);

  localparam int unsigned CNT_MAX = (DOOR_CYCLES > TRAVEL_CYCLES) ? DOOR_CYCLES : TRAVEL_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES);
  localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       pos_q, pos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;
  logic             open_q, open_d;

  logic [2:0] pos_step;
  logic [1:0] eval_floor;
  logic       clear, suppress;
  logic [2:0] req_up, req_down, req_in;
  logic       here, above, below, ahead, stop_req, press_here;
  logic       arrive_stop, take_decision;
  state_e     dec_state;
  logic [1:0] dec_dir;

  // While moving, flags are evaluated for the floor about to be reached.
  always_comb begin
    pos_step = pos_q;
    if (state_q == MOVING) pos_step = (dir_q == DIR_DOWN) ? pos_q - 3'd1 : pos_q + 3'd1;
    eval_floor = pos_step[2:1];
    suppress   = (state_q == DOOR_OPEN);
  end

  elevator_request_reg u_req (
    .clk        (clk),
    .reset_n    (reset_n),
    .button_up  (button_up),
    .button_down(button_down),
    .button_in  (button_in),
    .floor      (eval_floor),
    .dir        (dir_q),
    .clear      (clear),
    .suppress   (suppress),
    .req_up     (req_up),
    .req_down   (req_down),
    .req_in     (req_in),
    .here       (here),
    .above      (above),
    .below      (below),
    .ahead      (ahead),
    .stop_req   (stop_req),
    .press_here (press_here)
  );

  always_comb begin
    dec_state = IDLE;
    dec_dir   = DIR_STOP;
    if (here) begin
      dec_state = DOOR_OPEN;
      dec_dir   = dir_q;
    end else if (above && ((dir_q != DIR_DOWN) || !below)) begin
      dec_state = MOVING;
      dec_dir   = DIR_UP;
    end else if (below) begin
      dec_state = MOVING;
      dec_dir   = DIR_DOWN;
    end
  end

  assign arrive_stop = (pos_step == 3'd0) || (pos_step == 3'(POS_MAX)) || stop_req || !ahead;

  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    open_d        = open_q;
    clear         = 1'b0;
    take_decision = 1'b0;

    unique case (state_q)
      IDLE: take_decision = 1'b1;
      DOOR_OPEN: begin
        if (press_here) begin
          cnt_d = DOOR_LOAD;
        end else if (cnt_q <= CNT_ONE) begin
          open_d        = 1'b0;
          take_decision = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      MOVING: begin
        if (cnt_q <= CNT_ONE) begin
          pos_d = pos_step;
          cnt_d = TRAVEL_LOAD;
          if (!pos_step[0] && arrive_stop) begin
            state_d = DOOR_OPEN;
            cnt_d   = DOOR_LOAD;
            open_d  = 1'b1;
            clear   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_decision) begin
      state_d = dec_state;
      dir_d   = dec_dir;
      unique case (dec_state)
        DOOR_OPEN: begin
          cnt_d  = DOOR_LOAD;
          open_d = 1'b1;
          clear  = 1'b1;
        end
        MOVING: begin
          cnt_d  = TRAVEL_LOAD;
          open_d = 1'b0;
        end
        default: begin
          cnt_d  = '0;
          open_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pos_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_STOP;
      open_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      open_q  <= open_d;
    end
  end

  assign floor_cur = pos_q[2:1];
  assign half_cur  = pos_q[0];
  assign open_cur  = open_q;
  assign dir_cur   = dir_q;
  assign pending   = {req_in, req_down, req_up};
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_elevator_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized button traffic compared every cycle against a behavioural model.
module tb_elevator_sequencer;

  localparam int DC = 4;
  localparam int TC = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] bu, bd, bi;
  logic [1:0] floor_cur, dir_cur;
  logic       half_cur, open_cur, busy;
  logic [8:0] pending;

  elevator_sequencer #(.DOOR_CYCLES(DC), .TRAVEL_CYCLES(TC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .button_up  (bu),
    .button_down(bd),
    .button_in  (bi),
    .floor_cur  (floor_cur),
    .half_cur   (half_cur),
    .open_cur   (open_cur),
    .dir_cur    (dir_cur),
    .pending    (pending),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: position in half floors, direction -1/0/+1, mode 0 idle, 1 door, 2 travel
  int m_pos, m_dir, m_mode, m_tmr;
  bit m_open;
  bit r_up[3], r_dn[3], r_in[3];
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_at(int g);
    return r_up[g] || r_dn[g] || r_in[g];
  endfunction

  function automatic bit m_above(int f);
    for (int k = f + 1; k < 3; k++) if (m_at(k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_below(int f);
    for (int k = 0; k < f; k++) if (m_at(k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [8:0] m_pending();
    logic [8:0] p;
    p = '0;
    for (int k = 0; k < 3; k++) begin
      p[k]     = r_up[k];
      p[3 + k] = r_dn[k];
      p[6 + k] = r_in[k];
    end
    return p;
  endfunction

  function automatic int m_dir_enc();
    return (m_dir == 1) ? 1 : (m_dir == -1) ? 2 : 0;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_dir = 0; m_mode = 0; m_tmr = 0; m_open = 1'b0;
    for (int k = 0; k < 3; k++) begin
      r_up[k] = 1'b0; r_dn[k] = 1'b0; r_in[k] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [2:0] u, input logic [2:0] d, input logic [2:0] i);
    int f, clr, np, g, old_mode;
    bit ext, stop, take;
    f = m_pos / 2;
    clr = -1;
    take = 1'b0;
    old_mode = m_mode;
    ext = (f < 2 && u[f]) || (f > 0 && d[f]) || i[f];
    case (m_mode)
      0: take = 1'b1;
      1: begin
        if (ext) m_tmr = DC;
        else if (m_tmr == 1) begin m_open = 1'b0; take = 1'b1; end
        else m_tmr--;
      end
      default: begin
        if (m_tmr == 1) begin
          np = m_pos + m_dir;
          m_pos = np;
          m_tmr = TC;
          if (np % 2 == 0) begin
            g = np / 2;
            stop = (np == 0) || (np == 4) || r_in[g] || (m_dir > 0 && r_up[g]) ||
                   (m_dir < 0 && r_dn[g]) || !((m_dir > 0) ? m_above(g) : m_below(g));
            if (stop) begin m_mode = 1; m_tmr = DC; m_open = 1'b1; clr = g; end
          end
        end else m_tmr--;
      end
    endcase
    if (take) begin
      if (m_at(f)) begin m_mode = 1; m_tmr = DC; m_open = 1'b1; clr = f; end
      else if (m_above(f) && (m_dir != -1 || !m_below(f))) begin m_mode = 2; m_dir = 1; m_tmr = TC; end
      else if (m_below(f)) begin m_mode = 2; m_dir = -1; m_tmr = TC; end
      else begin m_mode = 0; m_dir = 0; end
    end
    for (int k = 0; k < 3; k++) begin
      if (!(old_mode == 1 && k == f)) begin
        if (k < 2 && u[k]) r_up[k] = 1'b1;
        if (k > 0 && d[k]) r_dn[k] = 1'b1;
        if (i[k]) r_in[k] = 1'b1;
      end
    end
    if (clr >= 0) begin
      r_up[clr] = 1'b0; r_dn[clr] = 1'b0; r_in[clr] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("floor_cur", int'(floor_cur), m_pos / 2);
      check("half_cur", int'(half_cur), m_pos % 2);
      check("open_cur", int'(open_cur), int'(m_open));
      check("dir_cur", int'(dir_cur), m_dir_enc());
      check("pending", int'(pending), int'(m_pending()));
      check("busy", int'(busy), int'(m_mode != 0));
    end
  end

  task automatic tick(input logic [2:0] u, input logic [2:0] d, input logic [2:0] i);
    @(negedge clk);
    bu = u; bd = d; bi = i;
    @(posedge clk);
    model_step(u, d, i);
    #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    bu = '0; bd = '0; bi = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;
  endtask

  function automatic logic [2:0] rnd3();
    logic [2:0] v;
    for (int k = 0; k < 3; k++) v[k] = ($urandom_range(0, 11) == 0);
    return v;
  endfunction

  int open_cnt, half_cnt, bad_pend, n_opens;
  int open_floor[2];
  bit prev_open;

  initial begin
    bu = '0; bd = '0; bi = '0;
    do_reset();

    // Quiet after reset: everything stays at zero
    for (int t = 0; t < 20; t++) begin
      tick(3'b000, 3'b000, 3'b000);
      check("reset_quiet", int'({floor_cur, half_cur, open_cur, dir_cur, pending, busy}), 0);
    end

    // Cabin press at the current floor
    open_cnt = 0;
    for (int t = 0; t < 10; t++) begin
      tick(3'b000, 3'b000, (t == 0) ? 3'b001 : 3'b000);
      if (open_cur) open_cnt++;
      if (t == 0) check("latch_in0", int'(pending), 9'h040);
      if (t == 1) check("cleared_on_open", int'(pending), 0);
      if (t == 5) check("idle_after_dwell", int'(busy), 0);
    end
    check("dwell_len", open_cnt, DC);

    // Two-floor trip up
    do_reset();
    half_cnt = 0;
    for (int t = 0; t < 15; t++) begin
      tick(3'b000, 3'b000, (t == 0) ? 3'b100 : 3'b000);
      if (half_cur) half_cnt++;
      if (t == 1) check("dir_up_set", int'(dir_cur), 1);
      if (t == 9) check("arrive_floor2", int'({floor_cur, open_cur}), 5);
    end
    check("half_cycles", half_cnt, 2 * TC);
    check("dir_stop_after", int'({dir_cur, busy}), 0);

    // Pass floor 1 going up, serve it on the way down
    do_reset();
    n_opens = 0;
    prev_open = 1'b0;
    for (int t = 0; t < 26; t++) begin
      tick(3'b000, (t == 0) ? 3'b010 : 3'b000, (t == 0) ? 3'b100 : 3'b000);
      if (open_cur && !prev_open) begin
        if (n_opens < 2) open_floor[n_opens] = int'(floor_cur);
        n_opens++;
      end
      prev_open = open_cur;
    end
    check("stop_count", n_opens, 2);
    check("first_stop", open_floor[0], 2);
    check("second_stop", open_floor[1], 1);
    check("all_served", int'(pending), 0);

    // Dwell extension at floor 1
    open_cnt = 0;
    bad_pend = 0;
    for (int t = 0; t < 12; t++) begin
      tick(3'b000, 3'b000, (t == 0 || t == 4) ? 3'b010 : 3'b000);
      if (open_cur) open_cnt++;
      if (t >= 1 && pending != 9'h000) bad_pend++;
    end
    check("extended_dwell", open_cnt, 3 + DC);
    check("ext_not_latched", bad_pend, 0);

    // Asynchronous reset mid-travel
    for (int t = 0; t < 4; t++) tick(3'b000, 3'b000, (t == 0) ? 3'b100 : 3'b000);
    check("mid_travel", int'({half_cur, dir_cur}), 5);
    #2;
    chk_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_reset", int'({floor_cur, half_cur, open_cur, dir_cur, pending, busy}), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // Random traffic against the model
    for (int t = 0; t < 1500; t++) begin
      if (t == 750) do_reset();
      tick(rnd3(), rnd3(), rnd3());
    end
    for (int t = 0; t < 40; t++) tick(3'b000, 3'b000, 3'b000);
    @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
